// File: rtl/data_sram_slave.sv
// Word-organised data RAM with byte strobes serving in-order pipelined load/store requests.
// Responses travel through a small latency queue and return as one-cycle data_ok pulses.
module data_sram_slave #(
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = 1,
  parameter int DEPTH      = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam logic [1:0] LAST_SLOT = 2'(DEPTH - 1);
  localparam logic [2:0] DEPTH_C   = 3'(DEPTH);
  localparam logic [2:0] LAT_INIT  = 3'(LATENCY - 1);

  logic [31:0] mem [2**ADDR_WIDTH];

  // Queue arrays are sized for the largest legal DEPTH so pointer width is fixed.
  logic [31:0] q_rdata [4];
  logic [2:0]  q_cnt   [4];
  logic [3:0]  q_valid;
  logic [1:0]  wr_ptr, rd_ptr;
  logic [2:0]  count;

  logic [ADDR_WIDTH-1:0] index;
  logic                  misaligned;
  logic                  accept;
  logic [31:0]           push_rdata;
  logic                  unused_addr;

  assign index       = addr[ADDR_WIDTH+1:2];
  assign unused_addr = ^addr[31:ADDR_WIDTH+2];

  function automatic logic [1:0] bump(input logic [1:0] p);
    return (p == LAST_SLOT) ? 2'd0 : p + 2'd1;
  endfunction

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    misaligned = 1'b0;
    if (size == 2'd1)
      misaligned = addr[0];
    else if (size[1])
      misaligned = (addr[1:0] != 2'b00);
    addr_ok    = !reset && (count < DEPTH_C);
    accept     = req && addr_ok;
    push_rdata = (!wr && !misaligned) ? mem[index] : 32'h0;
    data_ok    = q_valid[rd_ptr] && (q_cnt[rd_ptr] == 3'd0);
    rdata      = data_ok ? q_rdata[rd_ptr] : 32'h0;
  end

  // NOTE: the RAM array has no reset; contents survive reset and only the queue state is cleared.
  always_ff @(posedge clk) begin
    if (accept && wr && !misaligned) begin
      for (int i = 0; i < 4; i++)
        if (wstrb[i]) mem[index][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every read sees pre-edge values;
  // later assignments to the same slot in this block deliberately override earlier ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        q_rdata[i] <= 32'h0;
        q_cnt[i]   <= 3'd0;
      end
      q_valid <= 4'b0;
      wr_ptr  <= 2'd0;
      rd_ptr  <= 2'd0;
      count   <= 3'd0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (q_valid[i] && q_cnt[i] != 3'd0) q_cnt[i] <= q_cnt[i] - 3'd1;
      if (data_ok) begin
        q_valid[rd_ptr] <= 1'b0;
        rd_ptr          <= bump(rd_ptr);
      end
      if (accept) begin
        q_valid[wr_ptr] <= 1'b1;
        q_cnt[wr_ptr]   <= LAT_INIT;
        q_rdata[wr_ptr] <= push_rdata;
        wr_ptr          <= bump(wr_ptr);
      end
      case ({accept, data_ok})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

endmodule
